m1_stage: RTL

- First memory pipeline stage, directly downstream of the execute stage.
- Latches the execute-to-M1 bus and the "request issued" flag.
- Collects the DCache response (data_data_ok / data_rdata) for issued loads and stores, and holds the returned word while M2 stalls.
- Passes the instruction plus read data to M2, exports exception/eret/forwarding info back to EXE and ID, and drops stale DCache responses after a flush.

---
 rtl/m1_stage.sv | 118 +++++++++++
 1 files changed

// File: rtl/m1_stage.sv
// First memory stage: latches the EXE bus, collects the DCache response, holds it across M2 stalls.
// Optional define M1_FWD_LOAD_EN forwards load data on M1_result and drops m1s_load_op once data is in.
module m1_stage #(
    parameter int ES_BUS_WD = 138,
    parameter int M1_BUS_WD = 170,
    parameter int MAX_STALE = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 es_to_m1s_valid,
    input  logic [ES_BUS_WD-1:0] es_to_m1s_bus,
    input  logic                 es_req_issued,
    output logic                 m1s_allowin,
    input  logic                 m2s_allowin,
    output logic                 m1s_to_m2s_valid,
    output logic [M1_BUS_WD-1:0] m1s_to_m2s_bus,
    input  logic                 flush,
    output logic                 m1s_ex,
    output logic                 m1s_inst_eret,
    output logic [4:0]           M1_dest,
    output logic [31:0]          M1_result,
    output logic                 m1s_load_op,
    input  logic                 data_data_ok,
    input  logic [31:0]          data_rdata
);

    localparam int SW = $clog2(MAX_STALE + 1);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_WAIT,
        S_READY
    } state_t;

    state_t               state;
    logic [ES_BUS_WD-1:0] bus_r;
    logic [SW-1:0]        stale_cnt;
    logic [SW-1:0]        stale_next;
    logic [31:0]          rdata_hold;

    logic valid;
    logic resp_ok;
    logic capture;
    logic accept;
    logic stale_inc;
    logic stale_dec;
    logic [31:0] rdata_out;

    assign valid     = (state != S_EMPTY);
    assign resp_ok   = data_data_ok && (stale_cnt == '0);
    assign capture   = (state == S_WAIT) && resp_ok;

    assign m1s_to_m2s_valid = (state == S_READY) || capture;
    assign m1s_allowin      = (state == S_EMPTY)
                            || ((state == S_READY) && m2s_allowin)
                            || (capture && m2s_allowin);
    assign accept           = es_to_m1s_valid && m1s_allowin;

    // The capture cycle bypasses the hold register so M2 can take the word immediately.
    assign rdata_out      = capture ? data_rdata : rdata_hold;
    assign m1s_to_m2s_bus = {rdata_out, bus_r};

    assign m1s_ex        = valid && bus_r[127];
    assign m1s_inst_eret = valid && bus_r[120];
    assign M1_dest       = bus_r[68:64] & {5{valid && bus_r[69]}};

`ifdef M1_FWD_LOAD_EN
    assign M1_result   = ((state == S_READY) && bus_r[70]) ? rdata_hold :
                         (capture && bus_r[70])            ? data_rdata :
                                                             bus_r[63:32];
    assign m1s_load_op = (state == S_WAIT) && !capture && bus_r[133];
`else
    assign M1_result   = bus_r[63:32];
    assign m1s_load_op = valid && bus_r[133];
`endif

    // A flush orphans any request still in flight: the one we were waiting on, or one issued this cycle.
    assign stale_inc = flush && (((state == S_WAIT) && !capture) || (accept && es_req_issued));
    assign stale_dec = data_data_ok && (stale_cnt != '0);

    always_comb begin
        // NOTE: default first so every path assigns stale_next and no latch is inferred.
        stale_next = stale_cnt;
        if (stale_inc && !stale_dec) begin
            if (stale_cnt != SW'(MAX_STALE)) stale_next = stale_cnt + 1'b1;
        end else if (stale_dec && !stale_inc) begin
            stale_next = stale_cnt - 1'b1;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_EMPTY;
            bus_r      <= '0;
            stale_cnt  <= '0;
            rdata_hold <= '0;
        end else begin
            stale_cnt <= stale_next;
            if (capture) rdata_hold <= data_rdata;

            if (flush) begin
                state <= S_EMPTY;
                bus_r <= '0;
            end else if (accept) begin
                bus_r <= es_to_m1s_bus;
                state <= es_req_issued ? S_WAIT : S_READY;
            end else begin
                case (state)
                    S_WAIT:  if (capture) state <= m2s_allowin ? S_EMPTY : S_READY;
                    S_READY: if (m2s_allowin) state <= S_EMPTY;
                    default: state <= S_EMPTY;
                endcase
            end
        end
    end

endmodule
